// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funct codes,
// FSM states, instruction classes and the ALU/extender select values.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXE, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, HALT
    } state_e;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILL
    } iclass_e;

endpackage

// File: rtl/mc_decode.sv
// Pure combinational opcode/funct classifier; anything unrecognised is C_ILL.
module mc_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  cls_o
);
    iclass_e cls;
    logic    unused_fields;

    // rs/rt/rd/shamt/immediate never influence the class
    assign unused_fields = ^instr_i[25:6];

    always_comb begin
        cls = C_ILL;
        case (instr_i[31:26])
            OP_RTYPE: begin
                if (instr_i[5:0] == FN_ADDU)      cls = C_ADDU;
                else if (instr_i[5:0] == FN_SUBU) cls = C_SUBU;
            end
            OP_ORI:  cls = C_ORI;
            OP_LUI:  cls = C_LUI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_J:    cls = C_J;
            default: cls = C_ILL;
        endcase
    end

    assign cls_o = cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and counts retired instructions (one per pc_we pulse).
module mc_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic        npc_sel,
    output logic        isJump,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  ext_op,
    output logic [1:0]  alu_op,
    output logic        mem_re,
    output logic        mem_we,
    output logic        illegal,
    output logic [15:0] retired
);
    state_e      state_q, state_d;
    iclass_e     cls_q, cls_d, dec_cls;
    logic [3:0]  dec_raw;
    logic        illegal_q, illegal_d;
    logic [15:0] retired_q, retired_d;
    logic        ex_src;
    logic [1:0]  ex_ext, ex_op;
    logic        unused_zero;

    // branch outcome is resolved in the datapath, not here
    assign unused_zero = alu_zero;

    mc_decode u_dec (
        .instr_i (instr),
        .cls_o   (dec_raw)
    );
    assign dec_cls = iclass_e'(dec_raw);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            cls_q     <= C_ILL;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // ALU steering for the register-register / immediate ALU class
    always_comb begin
        ex_src = 1'b0;
        ex_ext = EXT_ZERO;
        ex_op  = ALU_ADD;
        case (cls_q)
            C_SUBU: ex_op = ALU_SUB;
            C_ORI: begin
                ex_src = 1'b1;
                ex_ext = EXT_ZERO;
                ex_op  = ALU_OR;
            end
            C_LUI: begin
                ex_src = 1'b1;
                ex_ext = EXT_LUI;
                ex_op  = ALU_ADD;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        npc_sel    = 1'b0;
        isJump     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        ext_op     = EXT_ZERO;
        alu_op     = ALU_ADD;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            FETCH: begin
                ir_we   = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = EXE;
                    C_LW, C_SW:                   state_d = MEM_ADDR;
                    C_BEQ:                        state_d = BRANCH;
                    C_J:                          state_d = JUMP;
                    default:                      state_d = HALT;
                endcase
            end
            EXE: begin
                alu_src = ex_src;
                ext_op  = ex_ext;
                alu_op  = ex_op;
                state_d = WB_ALU;
            end
            WB_ALU: begin
                alu_src = ex_src;
                ext_op  = ex_ext;
                alu_op  = ex_op;
                reg_we  = 1'b1;
                reg_dst = (cls_q == C_ADDU) || (cls_q == C_SUBU);
                pc_we   = 1'b1;
                state_d = FETCH;
            end
            MEM_ADDR: begin
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                state_d = (cls_q == C_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                mem_re  = 1'b1;
                if (mem_ready) state_d = WB_MEM;
            end
            WB_MEM: begin
                alu_src    = 1'b1;
                ext_op     = EXT_SIGN;
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                pc_we      = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                mem_we  = 1'b1;
                // the store retires in the same cycle memory accepts it
                if (mem_ready) begin
                    pc_we   = 1'b1;
                    state_d = FETCH;
                end
            end
            BRANCH: begin
                alu_op  = ALU_SUB;
                npc_sel = 1'b1;
                pc_we   = 1'b1;
                state_d = FETCH;
            end
            JUMP: begin
                isJump  = 1'b1;
                pc_we   = 1'b1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign illegal_d = illegal_q | (state_d == HALT);
    assign retired_d = pc_we ? retired_q + 16'd1 : retired_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-cycle vector table for the ALU class plus
// hand-written sequences for memory waits, branch/jump, halt, reset and wrap.
module tb_mc_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_we, pc_we, npc_sel, isJump, reg_we, reg_dst, mem_to_reg, alu_src;
    logic [1:0]  ext_op, alu_op;
    logic        mem_re, mem_we, illegal;
    logic [15:0] retired;
    logic [14:0] o;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [14:0] IR  = 15'h4000, PC  = 15'h2000, NS  = 15'h1000, IJ  = 15'h0800;
    localparam logic [14:0] RW  = 15'h0400, RD  = 15'h0200, MTR = 15'h0100, AS  = 15'h0080;
    localparam logic [14:0] EXL = 15'h0040, EXS = 15'h0020, OR_ = 15'h0010, SUB = 15'h0008;
    localparam logic [14:0] RE  = 15'h0004, WE  = 15'h0002, ILL = 15'h0001;

    localparam logic [31:0] I_ADDU = 32'h0022_1821;
    localparam logic [31:0] I_SUBU = 32'h0022_1823;
    localparam logic [31:0] I_ORI  = 32'h3422_0005;
    localparam logic [31:0] I_LUI  = 32'h3C01_ABCD;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    typedef struct {
        logic        r;
        logic [31:0] in;
        logic        mr;
        state_e      st;
        logic [14:0] eo;
        logic [15:0] ret;
    } vec_t;

    vec_t vq[$];

    mc_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .isJump(isJump),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .ext_op(ext_op), .alu_op(alu_op), .mem_re(mem_re), .mem_we(mem_we),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    assign o = {ir_we, pc_we, npc_sel, isJump, reg_we, reg_dst, mem_to_reg, alu_src,
                ext_op, alu_op, mem_re, mem_we, illegal};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] in, input logic m);
        @(negedge clk);
        rst = r; instr = in; mem_ready = m;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string nm, input state_e s, input logic [14:0] eo,
                              input logic [15:0] er);
        chk({nm, " state"},   {28'd0, dut.state_q}, {28'd0, s});
        chk({nm, " outputs"}, {17'd0, o},           {17'd0, eo});
        chk({nm, " retired"}, {16'd0, retired},     {16'd0, er});
    endtask

    task automatic add(input logic r, input logic [31:0] in, input logic mr, input state_e st,
                       input logic [14:0] eo, input logic [15:0] ret);
        vec_t v;
        v.r = r; v.in = in; v.mr = mr; v.st = st; v.eo = eo; v.ret = ret;
        vq.push_back(v);
    endtask

    int pcw;
    int rec;

    initial begin
        // ALU-class stream; mem_ready=1 in DECODE/EXE must be ignored and the
        // instr change during ORI's EXE must not alter ORI's write-back
        add(0, I_ADDU, 0, FETCH,  IR,             0);
        add(1, I_ADDU, 1, DECODE, 0,              0);
        add(1, I_ADDU, 1, EXE,    0,              0);
        add(1, I_ADDU, 0, WB_ALU, PC|RW|RD,       0);
        add(1, I_SUBU, 0, FETCH,  IR,             1);
        add(1, I_SUBU, 0, DECODE, 0,              1);
        add(1, I_SUBU, 0, EXE,    SUB,            1);
        add(1, I_SUBU, 0, WB_ALU, PC|RW|RD|SUB,   1);
        add(1, I_ORI,  0, FETCH,  IR,             2);
        add(1, I_ORI,  0, DECODE, 0,              2);
        add(1, I_ORI,  0, EXE,    AS|OR_,         2);
        add(1, I_BAD,  0, WB_ALU, PC|RW|AS|OR_,   2);
        add(1, I_LUI,  0, FETCH,  IR,             3);
        add(1, I_LUI,  0, DECODE, 0,              3);
        add(1, I_LUI,  0, EXE,    AS|EXL,         3);
        add(1, I_LUI,  0, WB_ALU, PC|RW|AS|EXL,   3);
        add(1, I_LUI,  0, FETCH,  IR,             4);

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].in, vq[i].mr);
            expect_all($sformatf("vec%0d", i), vq[i].st, vq[i].eo, vq[i].ret);
        end

        // lw with three wait cycles: 8 cycles, mem_re high 4
        step(0, I_LW, 0); expect_all("lw c1", FETCH, IR, 0);
        step(1, I_LW, 0); expect_all("lw c2", DECODE, 0, 0);
        step(1, I_LW, 1); expect_all("lw c3", MEM_ADDR, AS|EXS, 0);
        rec = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, I_LW, (k == 0) ? 1'b1 : 1'b0);
            expect_all($sformatf("lw wait%0d", k), MEM_RD, RE|AS|EXS, 0);
            rec += int'(mem_re);
        end
        chk("lw mem_re cycles", rec, 4);
        step(1, I_LW, 1); expect_all("lw c8", WB_MEM, RW|MTR|PC|AS|EXS, 0);
        step(1, I_LW, 0); expect_all("lw done", FETCH, IR, 1);

        // beq then j: npc_sel in cycle 3, isJump in cycle 6
        pcw = 0;
        step(0, I_BEQ, 0); expect_all("bj c1", FETCH, IR, 0);
        step(1, I_BEQ, 0); expect_all("bj c2", DECODE, 0, 0);           pcw += int'(pc_we);
        step(1, I_BEQ, 0); expect_all("bj c3", BRANCH, NS|PC|SUB, 0);   pcw += int'(pc_we);
        step(1, I_J, 0);   expect_all("bj c4", FETCH, IR, 1);           pcw += int'(pc_we);
        step(1, I_J, 0);   expect_all("bj c5", DECODE, 0, 1);           pcw += int'(pc_we);
        step(1, I_J, 0);   expect_all("bj c6", JUMP, IJ|PC, 1);         pcw += int'(pc_we);
        step(1, I_J, 0);   expect_all("bj c7", FETCH, IR, 2);           pcw += int'(pc_we);
        chk("bj pc_we pulses", pcw, 2);

        // illegal opcode 3Fh: HALT sticks until reset
        step(0, I_BAD, 0); expect_all("halt c1", FETCH, IR, 0);
        step(1, I_BAD, 0); expect_all("halt c2", DECODE, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(1, I_BAD, k[0]);
            expect_all($sformatf("halt hold%0d", k), HALT, ILL, 0);
        end
        step(0, I_BAD, 0); expect_all("halt reset", FETCH, IR, 0);

        // sw with one wait: pc_we coincides with mem_ready
        step(0, I_SW, 0); expect_all("sw c1", FETCH, IR, 0);
        step(1, I_SW, 0); expect_all("sw c2", DECODE, 0, 0);
        step(1, I_SW, 0); expect_all("sw c3", MEM_ADDR, AS|EXS, 0);
        step(1, I_SW, 0); expect_all("sw wait", MEM_WR, WE|AS|EXS, 0);
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("sw ready outputs", {17'd0, o}, {17'd0, WE|PC|AS|EXS});
        @(posedge clk); #1;
        expect_all("sw done", FETCH, IR, 1);

        // reset during MEM_WR wait abandons the store
        step(1, I_SW, 0); expect_all("swr c2", DECODE, 0, 1);
        step(1, I_SW, 0); expect_all("swr c3", MEM_ADDR, AS|EXS, 1);
        step(1, I_SW, 0); expect_all("swr wait0", MEM_WR, WE|AS|EXS, 1);
        step(1, I_SW, 0); expect_all("swr wait1", MEM_WR, WE|AS|EXS, 1);
        step(0, I_SW, 0); expect_all("swr reset", FETCH, IR, 0);
        step(1, I_ADDU, 0); expect_all("swr after", DECODE, 0, 0);

        // retired counter preloaded near the top, then two jumps wrap it
        step(0, I_J, 0); expect_all("wrap c1", FETCH, IR, 0);
        @(negedge clk);
        force dut.retired_q = 16'hFFFE;
        rst = 1'b1; instr = I_J; mem_ready = 1'b0;
        @(posedge clk); #1;
        release dut.retired_q;
        expect_all("wrap d1", DECODE, 0, 16'hFFFE);
        step(1, I_J, 0); expect_all("wrap j1", JUMP, IJ|PC, 16'hFFFE);
        step(1, I_J, 0); expect_all("wrap f1", FETCH, IR, 16'hFFFF);
        step(1, I_J, 0); expect_all("wrap d2", DECODE, 0, 16'hFFFF);
        step(1, I_J, 0); expect_all("wrap j2", JUMP, IJ|PC, 16'hFFFF);
        step(1, I_J, 0); expect_all("wrap f2", FETCH, IR, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
